// File: rtl/dec10_pkg.sv
// rtl/dec10_pkg.sv - shared types and helpers for the decimal-line to BCD encoder
package dec10_pkg;

    localparam int NUM_LINES = 10;
    localparam int CODE_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        RELEASE
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } line_class_t;

    // Highest set bit wins; callers only rely on this for single-hot input.
    function automatic logic [CODE_W-1:0] onehot10_to_bcd(input logic [NUM_LINES-1:0] act);
        logic [CODE_W-1:0] bcd;
        bcd = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (act[i]) begin
                bcd = CODE_W'(i);
            end
        end
        return bcd;
    endfunction

    function automatic line_class_t classify(input logic [NUM_LINES-1:0] act);
        int ones;
        ones = $countones(act);
        if (ones == 0) begin
            return NONE;
        end else if (ones == 1) begin
            return SINGLE;
        end else begin
            return MULTI;
        end
    endfunction

endpackage

// File: rtl/line_sync.sv
// rtl/line_sync.sv - multi-flop synchronizer for the active-low pad lines
module line_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage;

    // Reset to all ones so released (high) lines read as idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= '1;
        end else begin
            stage <= {stage[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/dec10_bcd_encoder.sv
// rtl/dec10_bcd_encoder.sv - debounced ten-line active-low to BCD encoder with one-deep output buffer
module dec10_bcd_encoder
    import dec10_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                 clk_pad,
    input  logic                 rst_pad,
    input  logic [NUM_LINES-1:0] line_n_pad,
    input  logic                 ready_pad,
    input  logic                 clear_pad,
    output logic [CODE_W-1:0]    code_pad,
    output logic                 valid_pad,
    output logic                 err_multi_pad,
    output logic                 overflow_pad
);

    localparam logic [3:0] DEB_CNT = 4'(DEBOUNCE_CYCLES);

    logic [NUM_LINES-1:0] sync_out;
    logic [NUM_LINES-1:0] act;
    line_class_t          cls;
    logic [CODE_W-1:0]    idx;
    state_t               state;
    logic [3:0]           cnt;
    logic [CODE_W-1:0]    cand;
    logic                 accept;
    logic                 multi_evt;
    logic                 drop_evt;

    line_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (NUM_LINES)
    ) u_line_sync (
        .clk (clk_pad),
        .rst (rst_pad),
        .d   (line_n_pad),
        .q   (sync_out)
    );

    always_comb begin
        act       = ~sync_out;
        cls       = classify(act);
        idx       = onehot10_to_bcd(act);
        accept    = (state == DEBOUNCE) && (cls == SINGLE) && (idx == cand) && (cnt == DEB_CNT);
        // Multi-hot only counts as an error while a fresh press could be forming.
        multi_evt = (cls == MULTI) && (state != RELEASE);
        drop_evt  = accept && valid_pad && !ready_pad;
    end

    always_ff @(posedge clk_pad or posedge rst_pad) begin
        if (rst_pad) begin
            state         <= IDLE;
            cnt           <= '0;
            cand          <= '0;
            code_pad      <= '0;
            valid_pad     <= 1'b0;
            err_multi_pad <= 1'b0;
            overflow_pad  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    case (cls)
                        SINGLE: begin
                            state <= DEBOUNCE;
                            cand  <= idx;
                            cnt   <= 4'd1;
                        end
                        MULTI: begin
                            state <= RELEASE;
                            cnt   <= '0;
                        end
                        default: begin
                            cnt <= '0;
                        end
                    endcase
                end
                DEBOUNCE: begin
                    case (cls)
                        SINGLE: begin
                            if (idx != cand) begin
                                cand <= idx;
                                cnt  <= 4'd1;
                            end else if (cnt == DEB_CNT) begin
                                state <= RELEASE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end
                        MULTI: begin
                            state <= RELEASE;
                            cnt   <= '0;
                        end
                        default: begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    endcase
                end
                RELEASE: begin
                    // Any activity restarts the quiet period, so a held key fires once.
                    if (cls == NONE) begin
                        if (cnt == DEB_CNT - 4'd1) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            if (accept && (!valid_pad || ready_pad)) begin
                code_pad  <= cand;
                valid_pad <= 1'b1;
            end else if (valid_pad && ready_pad) begin
                valid_pad <= 1'b0;
            end

            err_multi_pad <= multi_evt | (err_multi_pad & ~clear_pad);
            overflow_pad  <= drop_evt  | (overflow_pad  & ~clear_pad);
        end
    end

endmodule
